// File: rtl/e203_exu_pkg.sv
// Shared EXU definitions: flush FSM states, flush channel
// priority indices and the channel-index width helper.
package e203_exu_pkg;

    typedef logic [0:0] flush_state_t;

    localparam flush_state_t FLUSH_IDLE = 1'b0;
    localparam flush_state_t FLUSH_LOCK = 1'b1;

    localparam int FLUSH_CH_EXCP = 0;
    localparam int FLUSH_CH_BRCH = 1;

    function automatic int id_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/e203_exu_flush_prio.sv
// Lowest-index-wins priority encoder: one-hot grant,
// binary index and an any-request flag.
module e203_exu_flush_prio #(
    parameter int N   = 3,
    parameter int IDW = 1
) (
    input  logic [N-1:0]   req_i,
    output logic [N-1:0]   grant_o,
    output logic [IDW-1:0] idx_o,
    output logic           any_o
);

    assign grant_o = req_i & (~req_i + N'(1));
    assign any_o   = |req_i;

    always_comb begin
        idx_o = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (req_i[i]) begin
                idx_o = IDW'(i);
            end
        end
    end

endmodule

// File: rtl/e203_exu_flush_arb.sv
// N-channel prioritised pipeline-flush arbiter with grant lock,
// commit gating and a saturating flush counter.
module e203_exu_flush_arb
    import e203_exu_pkg::*;
#(
    parameter int NCH   = 3,
    parameter int PC_W  = 32,
    parameter int CNT_W = 16,
    parameter int ID_W  = id_w(NCH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NCH-1:0]    src_req,
    input  logic [NCH*PC_W-1:0] src_op1,
    input  logic [NCH*PC_W-1:0] src_op2,
    output logic [NCH-1:0]    src_ack,
    output logic              pipe_flush_req,
    output logic [PC_W-1:0]   pipe_flush_add_op1,
    output logic [PC_W-1:0]   pipe_flush_add_op2,
    input  logic              pipe_flush_ack,
    output logic              flush_pulse,
    output logic [ID_W-1:0]   flush_src_id,
    input  logic              cmt_valid,
    output logic              nonflush_cmt_ena,
    output logic [CNT_W-1:0]  flush_cnt,
    input  logic              cnt_clr
);

    flush_state_t    state_q, state_d;
    logic [ID_W-1:0] idx_q, idx_d;
    logic [PC_W-1:0] op1_q, op1_d;
    logic [PC_W-1:0] op2_q, op2_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic [NCH-1:0]  req_eff;
    logic [NCH-1:0]  win_oh;
    logic [ID_W-1:0] win_idx;
    logic            win_any;
    logic [PC_W-1:0] win_op1, win_op2;
    logic            lock;

    // Requests are masked while in reset so every output reads zero.
    assign req_eff = src_req & {NCH{rst_n}};

    e203_exu_flush_prio #(
        .N   (NCH),
        .IDW (ID_W)
    ) u_prio (
        .req_i   (req_eff),
        .grant_o (win_oh),
        .idx_o   (win_idx),
        .any_o   (win_any)
    );

    always_comb begin
        win_op1 = '0;
        win_op2 = '0;
        for (int i = 0; i < NCH; i++) begin
            if (win_oh[i]) begin
                win_op1 |= src_op1[i*PC_W +: PC_W];
                win_op2 |= src_op2[i*PC_W +: PC_W];
            end
        end
    end

    assign lock = (state_q == FLUSH_LOCK);

    assign pipe_flush_req     = lock | win_any;
    assign pipe_flush_add_op1 = lock ? op1_q : win_op1;
    assign pipe_flush_add_op2 = lock ? op2_q : win_op2;
    assign flush_src_id       = lock ? idx_q : win_idx;
    assign flush_pulse        = pipe_flush_req & pipe_flush_ack;
    assign nonflush_cmt_ena   = rst_n & cmt_valid & ~pipe_flush_req;
    assign flush_cnt          = cnt_q;

    always_comb begin
        src_ack = '0;
        for (int i = 0; i < NCH; i++) begin
            src_ack[i] = pipe_flush_ack &
                (lock ? (idx_q == ID_W'(i)) : win_oh[i]);
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        op1_d   = op1_q;
        op2_d   = op2_q;
        unique case (1'b1)
            (state_q == FLUSH_IDLE): begin
                if (win_any && !pipe_flush_ack) begin
                    state_d = FLUSH_LOCK;
                    idx_d   = win_idx;
                    op1_d   = win_op1;
                    op2_d   = win_op2;
                end
            end
            (state_q == FLUSH_LOCK): begin
                if (pipe_flush_ack) begin
                    state_d = FLUSH_IDLE;
                end
            end
            default: state_d = FLUSH_IDLE;
        endcase
    end

    always_comb begin
        cnt_d = cnt_q;
        if (cnt_clr) begin
            cnt_d = '0;
        end else if (flush_pulse && (cnt_q != '1)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= FLUSH_IDLE;
            idx_q   <= '0;
            op1_q   <= '0;
            op2_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            op1_q   <= op1_d;
            op2_q   <= op2_d;
            cnt_q   <= cnt_d;
        end
    end

    // A locked channel must keep requesting until it is acknowledged.
    a_lock_held: assert property (
        @(posedge clk) disable iff (!rst_n)
        lock |-> src_req[idx_q]
    );

    a_ack_onehot: assert property (
        @(posedge clk) disable iff (!rst_n)
        $onehot0(src_ack)
    );

endmodule

// File: tb/tb_e203_exu_flush_arb.sv
// Bench for e203_exu_flush_arb: directed vector table,
// hand-written lock/counter/reset sequences, random vs model.
module tb_e203_exu_flush_arb;

    localparam int NCH   = 3;
    localparam int PC_W  = 32;
    localparam int CNT_W = 16;
    localparam int ID_W  = 2;

    logic              clk = 1'b0;
    logic              rst_n = 1'b1;
    logic [NCH-1:0]    src_req = '0;
    logic [NCH*PC_W-1:0] src_op1;
    logic [NCH*PC_W-1:0] src_op2;
    logic [NCH-1:0]    src_ack;
    logic              pipe_flush_req;
    logic [PC_W-1:0]   pipe_flush_add_op1;
    logic [PC_W-1:0]   pipe_flush_add_op2;
    logic              pipe_flush_ack = 1'b0;
    logic              flush_pulse;
    logic [ID_W-1:0]   flush_src_id;
    logic              cmt_valid = 1'b0;
    logic              nonflush_cmt_ena;
    logic [CNT_W-1:0]  flush_cnt;
    logic              cnt_clr = 1'b0;

    logic [31:0] op1_arr [NCH];
    logic [31:0] op2_arr [NCH];

    assign src_op1 = {op1_arr[2], op1_arr[1], op1_arr[0]};
    assign src_op2 = {op2_arr[2], op2_arr[1], op2_arr[0]};

    always #5 clk = ~clk;

    e203_exu_flush_arb #(
        .NCH   (NCH),
        .PC_W  (PC_W),
        .CNT_W (CNT_W)
    ) dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .src_req            (src_req),
        .src_op1            (src_op1),
        .src_op2            (src_op2),
        .src_ack            (src_ack),
        .pipe_flush_req     (pipe_flush_req),
        .pipe_flush_add_op1 (pipe_flush_add_op1),
        .pipe_flush_add_op2 (pipe_flush_add_op2),
        .pipe_flush_ack     (pipe_flush_ack),
        .flush_pulse        (flush_pulse),
        .flush_src_id       (flush_src_id),
        .cmt_valid          (cmt_valid),
        .nonflush_cmt_ena   (nonflush_cmt_ena),
        .flush_cnt          (flush_cnt),
        .cnt_clr            (cnt_clr)
    );

    typedef struct {
        logic [2:0]  req;
        logic        ack;
        logic        cmt;
        logic        clr;
        logic        e_preq;
        logic [2:0]  e_ack;
        logic [1:0]  e_id;
        logic [31:0] e_op1;
        logic [31:0] e_op2;
        logic        e_nce;
        logic [15:0] e_cnt;
    } vec_t;

    int n_pass = 0;
    int n_total = 0;

    task automatic chk(input string nm,
                       input logic [63:0] act,
                       input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h want %0h", nm, act, exp);
    endtask

    task automatic chk_out(input string tag,
                           input logic preq,
                           input logic [2:0] ack,
                           input logic [1:0] id,
                           input logic [31:0] o1,
                           input logic [31:0] o2);
        chk({tag, ".req"}, 64'(pipe_flush_req), 64'(preq));
        chk({tag, ".ack"}, 64'(src_ack), 64'(ack));
        chk({tag, ".id"}, 64'(flush_src_id), 64'(id));
        chk({tag, ".op1"}, 64'(pipe_flush_add_op1), 64'(o1));
        chk({tag, ".op2"}, 64'(pipe_flush_add_op2), 64'(o2));
        chk({tag, ".pulse"}, 64'(flush_pulse),
            64'(preq & pipe_flush_ack));
    endtask

    task automatic def_ops();
        for (int i = 0; i < NCH; i++) begin
            op1_arr[i] = 32'h8000_0000 | (i << 8);
            op2_arr[i] = 32'(i * 4);
        end
    endtask

    task automatic drive(input logic [2:0] r, input logic a,
                         input logic c, input logic cl);
        src_req = r;
        pipe_flush_ack = a;
        cmt_valid = c;
        cnt_clr = cl;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    localparam logic [31:0] C0A = 32'h8000_0000;
    localparam logic [31:0] C1A = 32'h8000_0100;
    localparam logic [31:0] C2A = 32'h8000_0200;

    vec_t vecs [13];

    // reference model state for the random phase
    int          lk;
    logic [31:0] lop1, lop2;
    int          mcnt;

    initial begin
        vecs[0]  = '{3'b000,1'b0,1'b1,1'b0, 1'b0,3'b000,2'd0,0,  0,1'b1,16'd0};
        vecs[1]  = '{3'b010,1'b1,1'b0,1'b0, 1'b1,3'b010,2'd1,C1A,4,1'b0,16'd0};
        vecs[2]  = '{3'b000,1'b0,1'b0,1'b0, 1'b0,3'b000,2'd0,0,  0,1'b0,16'd1};
        vecs[3]  = '{3'b110,1'b1,1'b0,1'b0, 1'b1,3'b010,2'd1,C1A,4,1'b0,16'd1};
        vecs[4]  = '{3'b111,1'b1,1'b0,1'b0, 1'b1,3'b001,2'd0,C0A,0,1'b0,16'd2};
        vecs[5]  = '{3'b110,1'b1,1'b0,1'b0, 1'b1,3'b010,2'd1,C1A,4,1'b0,16'd3};
        vecs[6]  = '{3'b100,1'b1,1'b0,1'b0, 1'b1,3'b100,2'd2,C2A,8,1'b0,16'd4};
        vecs[7]  = '{3'b000,1'b0,1'b0,1'b0, 1'b0,3'b000,2'd0,0,  0,1'b0,16'd5};
        vecs[8]  = '{3'b001,1'b0,1'b1,1'b0, 1'b1,3'b000,2'd0,C0A,0,1'b0,16'd5};
        vecs[9]  = '{3'b001,1'b1,1'b1,1'b0, 1'b1,3'b001,2'd0,C0A,0,1'b0,16'd5};
        vecs[10] = '{3'b000,1'b0,1'b1,1'b0, 1'b0,3'b000,2'd0,0,  0,1'b1,16'd6};
        vecs[11] = '{3'b100,1'b1,1'b0,1'b1, 1'b1,3'b100,2'd2,C2A,8,1'b0,16'd6};
        vecs[12] = '{3'b000,1'b0,1'b0,1'b0, 1'b0,3'b000,2'd0,0,  0,1'b0,16'd0};

        def_ops();
        drive(3'b000, 1'b0, 1'b0, 1'b0);

        // reset state
        #2 rst_n = 1'b0;
        #1;
        chk_out("reset", 1'b0, 3'b000, 2'd0, 32'd0, 32'd0);
        chk("reset.cnt", 64'(flush_cnt), 64'd0);
        chk("reset.nce", 64'(nonflush_cmt_ena), 64'd0);
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        next_cycle();

        // directed vector table
        for (int v = 0; v < 13; v++) begin
            drive(vecs[v].req, vecs[v].ack, vecs[v].cmt, vecs[v].clr);
            @(negedge clk);
            chk_out($sformatf("vec%0d", v), vecs[v].e_preq,
                    vecs[v].e_ack, vecs[v].e_id,
                    vecs[v].e_op1, vecs[v].e_op2);
            chk($sformatf("vec%0d.nce", v),
                64'(nonflush_cmt_ena), 64'(vecs[v].e_nce));
            chk($sformatf("vec%0d.cnt", v),
                64'(flush_cnt), 64'(vecs[v].e_cnt));
            next_cycle();
        end

        // lock and hold: ch2 operands change, ch0 raises late
        drive(3'b100, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        chk_out("lockA", 1'b1, 3'b000, 2'd2, C2A, 32'd8);
        next_cycle();
        op1_arr[2] = 32'hDEAD_BEEF;
        op2_arr[2] = 32'h0000_1234;
        @(negedge clk);
        chk_out("lockB", 1'b1, 3'b000, 2'd2, C2A, 32'd8);
        next_cycle();
        drive(3'b101, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        chk_out("lockC", 1'b1, 3'b000, 2'd2, C2A, 32'd8);
        next_cycle();
        drive(3'b101, 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        chk_out("lockD", 1'b1, 3'b100, 2'd2, C2A, 32'd8);
        next_cycle();
        drive(3'b001, 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        chk_out("lockE", 1'b1, 3'b001, 2'd0, C0A, 32'd0);
        next_cycle();
        drive(3'b000, 1'b0, 1'b0, 1'b0);
        def_ops();
        @(negedge clk);
        chk("lock.cnt", 64'(flush_cnt), 64'd2);
        next_cycle();

        // counter saturation from a preloaded value
        force dut.cnt_q = 16'hFFFE;
        #1 release dut.cnt_q;
        drive(3'b001, 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        chk("sat.pre", 64'(flush_cnt), 64'hFFFE);
        for (int k = 0; k < 3; k++) begin
            next_cycle();
            @(negedge clk);
            chk($sformatf("sat%0d", k), 64'(flush_cnt), 64'hFFFF);
        end
        next_cycle();
        drive(3'b001, 1'b1, 1'b0, 1'b1);
        @(negedge clk);
        chk("clr.pulse", 64'(flush_pulse), 64'd1);
        next_cycle();
        drive(3'b000, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        chk("clr.cnt", 64'(flush_cnt), 64'd0);
        next_cycle();

        // one flush so the counter is non-zero, then reset mid-lock
        drive(3'b100, 1'b1, 1'b0, 1'b0);
        next_cycle();
        drive(3'b010, 1'b0, 1'b1, 1'b0);
        @(negedge clk);
        chk_out("rlk.pre", 1'b1, 3'b000, 2'd1, C1A, 32'd4);
        next_cycle();
        pipe_flush_ack = 1'b1;
        rst_n = 1'b0;
        #1;
        chk_out("rlk.in", 1'b0, 3'b000, 2'd0, 32'd0, 32'd0);
        chk("rlk.cnt", 64'(flush_cnt), 64'd0);
        chk("rlk.nce", 64'(nonflush_cmt_ena), 64'd0);
        pipe_flush_ack = 1'b0;
        @(negedge clk) rst_n = 1'b1;
        #1;
        chk_out("rlk.post", 1'b1, 3'b000, 2'd1, C1A, 32'd4);
        next_cycle();
        pipe_flush_ack = 1'b1;
        @(negedge clk);
        chk_out("rlk.ack", 1'b1, 3'b010, 2'd1, C1A, 32'd4);
        next_cycle();
        drive(3'b000, 1'b0, 1'b0, 1'b0);

        // random phase against the behavioural model
        rst_n = 1'b0;
        next_cycle();
        @(negedge clk) rst_n = 1'b1;
        next_cycle();
        lk = -1;
        lop1 = '0;
        lop2 = '0;
        mcnt = 0;
        begin
            logic [2:0]  held;
            int          w;
            logic        e_preq;
            logic [2:0]  e_ack;
            logic [31:0] e1, e2;
            held = '0;
            for (int n = 0; n < 600; n++) begin
                for (int i = 0; i < NCH; i++) begin
                    if (!held[i] && $urandom_range(2) == 0)
                        held[i] = 1'b1;
                    op1_arr[i] = $urandom;
                    op2_arr[i] = $urandom;
                end
                drive(held, 1'($urandom_range(1)),
                      1'($urandom_range(1)),
                      1'($urandom_range(15) == 0));
                @(negedge clk);
                w = lk;
                if (w < 0) begin
                    for (int i = NCH - 1; i >= 0; i--)
                        if (held[i]) w = i;
                end
                e_preq = (w >= 0);
                e1 = (w < 0) ? 32'd0 : (lk >= 0) ? lop1 : op1_arr[w];
                e2 = (w < 0) ? 32'd0 : (lk >= 0) ? lop2 : op2_arr[w];
                e_ack = (e_preq && pipe_flush_ack) ? 3'(1 << w) : 3'b000;
                chk_out($sformatf("rnd%0d", n), e_preq, e_ack,
                        e_preq ? 2'(w) : 2'd0, e1, e2);
                chk($sformatf("rnd%0d.nce", n), 64'(nonflush_cmt_ena),
                    64'(cmt_valid && !e_preq));
                chk($sformatf("rnd%0d.cnt", n), 64'(flush_cnt),
                    64'(mcnt));
                if (cnt_clr) mcnt = 0;
                else if (e_preq && pipe_flush_ack && mcnt < 65535)
                    mcnt++;
                if (e_preq) begin
                    if (pipe_flush_ack) lk = -1;
                    else if (lk < 0) begin
                        lk = w;
                        lop1 = op1_arr[w];
                        lop2 = op2_arr[w];
                    end
                end
                held = held & ~e_ack;
                next_cycle();
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/e203_exu_flush_arb.md
# e203_exu_flush_arb

Parametrised N-channel pipeline-flush arbiter for the EXU commit stage. It generalises the two-source exception/branch-mispredict flush merge into NCH prioritised requesters. A granted channel is locked and its flush operands are registered until the IFU acknowledges. It also provides commit gating, a grant-source ID and a saturating flush counter for performance/debug CSRs.

## Interface
- NCH, 3: number of flush requesters; channel 0 has highest priority (exception/IRQ), then mispredict, then others.
- PC_W, 32: width of flush adder operands (E203_PC_SIZE).
- CNT_W, 16: flush event counter width.
- ID_W, $clog2(NCH) (min 1): channel index width.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- src_req  in  NCH  per-channel flush request; held until the matching src_ack.
- src_op1  in  NCH*PC_W  per-channel adder operand 1, channel i at [i*PC_W +: PC_W].
- src_op2  in  NCH*PC_W  per-channel adder operand 2, same packing.
- src_ack  out  NCH  one-hot completion pulse to the served channel.
- pipe_flush_req  out  1  flush request to IFU.
- pipe_flush_add_op1  out  PC_W  operand 1 to the IFU adder.
- pipe_flush_add_op2  out  PC_W  operand 2 to the IFU adder.
- pipe_flush_ack  in  1  IFU accepts the flush.
- flush_pulse  out  1  pipe_flush_req & pipe_flush_ack.
- flush_src_id  out  ID_W  channel currently driving the flush.
- cmt_valid  in  1  commit handshake completes this cycle.
- nonflush_cmt_ena  out  1  cmt_valid & ~pipe_flush_req.
- flush_cnt  out  CNT_W  saturating count of completed flushes.
- cnt_clr  in  1  synchronous clear of flush_cnt.

## Operation
- FSM states IDLE and LOCK. Reset state is IDLE.
- IDLE:
  - If any src_req is set, winner w = lowest set index.
  - pipe_flush_req=1; operands taken combinationally from channel w; flush_src_id=w.
  - If pipe_flush_ack is set: src_ack[w]=1 and the FSM stays IDLE.
  - Otherwise: register w, src_op1[w] and src_op2[w], then go to LOCK.
- LOCK:
  - pipe_flush_req=1; operands and ID come from the registers.
  - src_req is ignored, and higher-priority requests do not preempt.
  - On pipe_flush_ack: src_ack[locked]=1, go to IDLE.
  - A channel newly requesting in the ack cycle is evaluated next cycle in IDLE.
- Retracted request: if the locked channel drops src_req before ack, the flush still completes with the registered operands. This is a protocol violation and is flagged by assertion only.
- Counter: flush_cnt increments on flush_pulse and saturates at all-ones. cnt_clr takes priority over the increment.
- Outputs in IDLE with no request: pipe_flush_req=0, operands=0, flush_src_id=0.

## Timing
- Reset values:
  - Outputs: src_ack=0, pipe_flush_req=0, operands=0, flush_src_id=0, flush_pulse=0, nonflush_cmt_ena=0, flush_cnt=0.
  - Internal: locked index and operand registers are 0.
- Latency: IDLE request to pipe_flush_req is 0 cycles (combinational). Ack to src_ack is 0 cycles.
- src_ack is asserted for exactly one cycle per flush. At most one bit is set in any cycle.
- Flush duration: one flush per ack. Back-to-back flushes need an IDLE cycle after LOCK; from IDLE with same-cycle ack, a flush can be served every cycle.
- Reset asserted mid-LOCK: the FSM returns to IDLE asynchronously, no src_ack is issued, and the counter clears.
- NCH=1: ID_W=1, flush_src_id is always 0, and priority logic degenerates to a pass-through.

## Structure
- Shared package (e203_exu_pkg): flush-state enum (IDLE/LOCK), the channel priority index constants (FLUSH_CH_EXCP=0, FLUSH_CH_BRCH=1), and the ID_W function.
- One sub-module, e203_exu_flush_prio: combinational NCH-bit lowest-index priority encoder producing a one-hot grant and a binary index. Reused by the IRQ select logic.
- Top block holds the FSM, operand registers, mux and counter. Target size is ~200 lines.

## Test plan
- Single channel, immediate ack: NCH=3, src_req=3'b010, op1=0x8000_0100, op2=0x4, ack same cycle. Required: pipe_flush_req=1, ops match, src_ack=3'b010, flush_pulse=1, flush_cnt=1, FSM stays IDLE.
- Priority: src_req=3'b110 then 3'b111, ack each cycle. Required: grants ch1, then ch0, then ch1, then ch2 in order; flush_src_id = 1, 0, 1, 2.
- Lock and hold: ch2 requests, no ack for 3 cycles, ch0 raises in cycle 2, ch2 operands change in cycle 1. Required: ops stay at ch2's first-cycle values, no preemption, src_ack=3'b100 on ack; ch0 served next cycle.
- Commit gating: cmt_valid=1 with pipe_flush_req=1 gives nonflush_cmt_ena=0; cmt_valid=1 in IDLE with no request gives nonflush_cmt_ena=1.
- Counter: preload to 0xFFFE via 2 flushes at CNT_W=16 and force, then 3 more flushes. Required: saturates at 0xFFFF. cnt_clr together with flush_pulse gives 0.
- Reset in LOCK: assert rst_n=0 while ch1 is locked. Required: all outputs 0 immediately, no src_ack. After release with src_req still 3'b010, a fresh IDLE grant is issued.
